// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - shared widths, PE latency and FSM state type for conv_row_sched
package pe_ctrl_pkg;
    localparam int DATA_W = 8;
    localparam int PSUM_W = 20;
    localparam int PE_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOADW,
        STREAM,
        DRAIN
    } state_t;
endpackage

// File: rtl/conv_row_sched_if.sv
// rtl/conv_row_sched_if.sv - weight/pixel/result streams and PE column buses of conv_row_sched
interface conv_row_sched_if #(
    parameter int NUM_PE = 3,
    parameter int LEN_W  = 7
);
    logic                                    w_valid;
    logic                                    w_ready;
    logic [pe_ctrl_pkg::DATA_W-1:0]          w_data;
    logic [LEN_W-1:0]                        cfg_len;
    logic                                    start;
    logic                                    busy;
    logic                                    done;
    logic                                    err;
    logic                                    px_valid;
    logic                                    px_ready;
    logic [pe_ctrl_pkg::DATA_W-1:0]          px_data;
    logic [NUM_PE*pe_ctrl_pkg::DATA_W-1:0]   pe_ifmap;
    logic [NUM_PE*pe_ctrl_pkg::DATA_W-1:0]   pe_filter;
    logic [pe_ctrl_pkg::PSUM_W-1:0]          pe_psum_in;
    logic [pe_ctrl_pkg::PSUM_W-1:0]          pe_psum_out;
    logic                                    out_valid;
    logic [pe_ctrl_pkg::PSUM_W-1:0]          out_data;
    logic                                    out_last;

    modport slave (
        input  w_valid, w_data, cfg_len, start, px_valid, px_data, pe_psum_out,
        output w_ready, busy, done, err, px_ready, pe_ifmap, pe_filter, pe_psum_in,
               out_valid, out_data, out_last
    );

    modport master (
        output w_valid, w_data, cfg_len, start, px_valid, px_data, pe_psum_out,
        input  w_ready, busy, done, err, px_ready, pe_ifmap, pe_filter, pe_psum_in,
               out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_row_sched_px_window.sv
// rtl/conv_row_sched_px_window.sv - sliding pixel window, oldest pixel at slice 0
module px_window #(
    parameter int NUM_PE = 3,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     shift_i,
    input  logic [DATA_W-1:0]        din_i,
    output logic [NUM_PE*DATA_W-1:0] dout_o
);
    logic [DATA_W-1:0] win_q [NUM_PE];

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int i = 0; i < NUM_PE; i++) begin
                win_q[i] <= '0;
            end
        end else if (shift_i) begin
            for (int i = 0; i < NUM_PE - 1; i++) begin
                win_q[i] <= win_q[i+1];
            end
            win_q[NUM_PE-1] <= din_i;
        end
    end

    always_comb begin
        dout_o = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            dout_o[i*DATA_W +: DATA_W] = win_q[i];
        end
    end
endmodule

// File: rtl/conv_row_sched.sv
// rtl/conv_row_sched.sv - tap loading, pixel windowing and PE latency tracking for one conv row
module conv_row_sched
    import pe_ctrl_pkg::*;
#(
    parameter int NUM_PE = 3,
    parameter int MAX_W  = 64,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    conv_row_sched_if.slave   bus
);
    localparam int              IDX_W    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [LEN_W:0]  NPE_C    = (LEN_W+1)'(NUM_PE);
    localparam logic [LEN_W:0]  MAXW_C   = (LEN_W+1)'(MAX_W);
    localparam logic [LEN_W:0]  ONE_C    = (LEN_W+1)'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    tap_idx_q, tap_idx_d;
    logic                loaded_q, loaded_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                fire_q, last_q;
    logic [PE_LAT-1:0]   vline_q, lline_q;
    logic                out_valid_q, out_last_q;
    logic [PSUM_W-1:0]   out_data_q;
    logic [DATA_W-1:0]   taps_q [NUM_PE];

    logic                tap_we;
    logic [IDX_W-1:0]    tap_waddr;
    logic                win_clr;
    logic                fire, fire_last;
    logic                px_accept;
    logic                len_ok;
    logic [LEN_W:0]      acc_next;
    logic [NUM_PE*DATA_W-1:0] win_flat;
    logic [NUM_PE*DATA_W-1:0] filt_flat;

    assign px_accept = bus.px_valid && (state_q == STREAM);
    assign len_ok    = ({1'b0, bus.cfg_len} >= NPE_C) && ({1'b0, bus.cfg_len} <= MAXW_C);
    assign acc_next  = {1'b0, acc_cnt_q} + ONE_C;

    // A weight word in IDLE always wins over a simultaneous start.
    always_comb begin
        state_d   = state_q;
        tap_idx_d = tap_idx_q;
        loaded_d  = loaded_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        tap_we    = 1'b0;
        tap_waddr = tap_idx_q;
        err_d     = 1'b0;
        done_d    = 1'b0;
        win_clr   = 1'b0;
        fire      = 1'b0;
        fire_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.w_valid) begin
                    tap_we    = 1'b1;
                    tap_waddr = '0;
                    if (NUM_PE == 1) begin
                        loaded_d = 1'b1;
                    end else begin
                        loaded_d  = 1'b0;
                        tap_idx_d = IDX_W'(1);
                        state_d   = LOADW;
                    end
                end else if (bus.start && loaded_q) begin
                    if (len_ok) begin
                        len_d     = bus.cfg_len;
                        acc_cnt_d = '0;
                        win_clr   = 1'b1;
                        state_d   = STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOADW: begin
                if (bus.w_valid) begin
                    tap_we = 1'b1;
                    if (tap_idx_q == LAST_IDX) begin
                        loaded_d  = 1'b1;
                        tap_idx_d = '0;
                        state_d   = IDLE;
                    end else begin
                        tap_idx_d = tap_idx_q + IDX_W'(1);
                    end
                end
            end
            STREAM: begin
                if (px_accept) begin
                    acc_cnt_d = acc_next[LEN_W-1:0];
                    fire      = (acc_next >= NPE_C);
                    if (acc_next == {1'b0, len_q}) begin
                        fire_last = 1'b1;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_last_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tap_idx_q   <= '0;
            loaded_q    <= 1'b0;
            len_q       <= '0;
            acc_cnt_q   <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            fire_q      <= 1'b0;
            last_q      <= 1'b0;
            vline_q     <= '0;
            lline_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tap_idx_q   <= tap_idx_d;
            loaded_q    <= loaded_d;
            len_q       <= len_d;
            acc_cnt_q   <= acc_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            fire_q      <= fire;
            last_q      <= fire_last;
            // Valid/last ride alongside the PE register stages.
            vline_q     <= (vline_q << 1) | PE_LAT'(fire_q);
            lline_q     <= (lline_q << 1) | PE_LAT'(last_q);
            out_valid_q <= vline_q[PE_LAT-1];
            out_last_q  <= lline_q[PE_LAT-1];
            if (vline_q[PE_LAT-1]) begin
                out_data_q <= bus.pe_psum_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PE; i++) begin
            if (rst) begin
                taps_q[i] <= '0;
            end else if (tap_we && (tap_waddr == IDX_W'(i))) begin
                taps_q[i] <= bus.w_data;
            end
        end
    end

    always_comb begin
        filt_flat = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            filt_flat[i*DATA_W +: DATA_W] = taps_q[i];
        end
    end

    px_window #(
        .NUM_PE (NUM_PE),
        .DATA_W (DATA_W)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (win_clr),
        .shift_i (px_accept),
        .din_i   (bus.px_data),
        .dout_o  (win_flat)
    );

    assign bus.w_ready    = (state_q == IDLE) || (state_q == LOADW);
    assign bus.px_ready   = (state_q == STREAM);
    assign bus.busy       = (state_q == STREAM) || (state_q == DRAIN);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.pe_ifmap   = fire_q ? win_flat : '0;
    assign bus.pe_filter  = filt_flat;
    assign bus.pe_psum_in = '0;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
endmodule

// File: tb/tb_conv_row_sched.sv
// tb/tb_conv_row_sched.sv - directed scoreboard bench for conv_row_sched with a 2-stage PE column model
module tb_conv_row_sched;
    import pe_ctrl_pkg::*;

    localparam int NUM_PE = 3;
    localparam int MAX_W  = 64;
    localparam int LEN_W  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_row_sched_if #(.NUM_PE(NUM_PE), .LEN_W(LEN_W)) bus_if ();

    conv_row_sched #(
        .NUM_PE (NUM_PE),
        .MAX_W  (MAX_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        int val;
        bit last;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   tb_taps[NUM_PE];
    int   pix[$];
    int   row_len = 0;
    int   out_cnt = 0;
    int   out_cycs[$];
    int   acc_cyc[$];
    int   last_data = 0;

    // PE column: unsigned ifmap times signed filter, two register stages.
    logic [PSUM_W-1:0] s1 = '0;
    logic [PSUM_W-1:0] s2 = '0;

    function automatic logic [PSUM_W-1:0] pe_sum(input logic [NUM_PE*8-1:0] ifm,
                                                 input logic [NUM_PE*8-1:0] flt,
                                                 input logic [PSUM_W-1:0]   pin);
        int s;
        logic [31:0] r;
        s = int'($signed(pin));
        for (int i = 0; i < NUM_PE; i++) begin
            s += int'(ifm[i*8 +: 8]) * int'($signed(flt[i*8 +: 8]));
        end
        r = 32'(s);
        return r[PSUM_W-1:0];
    endfunction

    always @(posedge clk) begin
        s1  <= pe_sum(bus_if.pe_ifmap, bus_if.pe_filter, bus_if.pe_psum_in);
        s2  <= s1;
        cyc <= cyc + 1;
    end
    assign bus_if.pe_psum_out = s2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus_if.out_valid) begin
            out_cnt++;
            out_cycs.push_back(cyc);
            last_data = int'(bus_if.out_data);
            if (sb.size() == 0) begin
                chk("stray_out_valid", 32'(bus_if.out_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(bus_if.out_data), 32'(e.val) & 32'h000F_FFFF);
                chk("out_last", 32'(bus_if.out_last), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_taps(input int a, input int b, input int c);
        int t[NUM_PE];
        t = '{a, b, c};
        for (int i = 0; i < NUM_PE; i++) begin
            bus_if.w_valid = 1'b1;
            bus_if.w_data  = 8'(t[i]);
            tb_taps[i]     = t[i];
            tick();
        end
        bus_if.w_valid = 1'b0;
    endtask

    task automatic start_row(input int len);
        bus_if.cfg_len = LEN_W'(len);
        bus_if.start   = 1'b1;
        row_len        = len;
        pix.delete();
        out_cycs.delete();
        acc_cyc.delete();
        out_cnt = 0;
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic send_px(input int v);
        int n;
        int s;
        exp_t e;
        n = 0;
        while (!bus_if.px_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("px_ready_timeout", 32'(bus_if.px_ready), 32'h1);
        bus_if.px_valid = 1'b1;
        bus_if.px_data  = 8'(v);
        acc_cyc.push_back(cyc);
        pix.push_back(v);
        if (pix.size() >= NUM_PE) begin
            s = 0;
            for (int i = 0; i < NUM_PE; i++) begin
                s += pix[pix.size() - NUM_PE + i] * tb_taps[i];
            end
            e.val  = s;
            e.last = (pix.size() == row_len);
            sb.push_back(e);
        end
        tick();
        bus_if.px_valid = 1'b0;
    endtask

    task automatic wait_last_and_done();
        int n;
        n = 0;
        while (!bus_if.out_last && n < 40) begin
            tick();
            n++;
        end
        chk("out_last_seen", 32'(bus_if.out_last), 32'h1);
        tick();
        chk("done_pulse", 32'(bus_if.done), 32'h1);
        chk("busy_after_done", 32'(bus_if.busy), 32'h0);
        chk("out_count", 32'(out_cnt), 32'(row_len - NUM_PE + 1));
    endtask

    initial begin
        int bad;
        bus_if.w_valid  = 1'b0;
        bus_if.w_data   = '0;
        bus_if.cfg_len  = '0;
        bus_if.start    = 1'b0;
        bus_if.px_valid = 1'b0;
        bus_if.px_data  = '0;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(bus_if.busy), 32'h0);
        chk("rst_done", 32'(bus_if.done), 32'h0);
        chk("rst_err", 32'(bus_if.err), 32'h0);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
        chk("rst_out_last", 32'(bus_if.out_last), 32'h0);
        chk("rst_px_ready", 32'(bus_if.px_ready), 32'h0);
        chk("rst_w_ready", 32'(bus_if.w_ready), 32'h1);
        chk("rst_out_data", 32'(bus_if.out_data), 32'h0);
        chk("rst_pe_ifmap", 32'(bus_if.pe_ifmap), 32'h0);
        chk("rst_pe_filter", 32'(bus_if.pe_filter), 32'h0);
        rst = 1'b0;
        tick();

        // Row 1: taps 1,2,3, pixels 1..5 back to back.
        load_taps(1, 2, 3);
        chk("t1_pe_filter", 32'(bus_if.pe_filter), 32'h0003_0201);
        start_row(5);
        chk("t1_busy", 32'(bus_if.busy), 32'h1);
        chk("t1_px_ready", 32'(bus_if.px_ready), 32'h1);
        for (int v = 1; v <= 5; v++) send_px(v);
        wait_last_and_done();
        chk("t1_latency", 32'(out_cycs[0] - acc_cyc[2]), 32'd4);
        chk("t1_last_value", 32'(last_data), 32'd26);

        // Most negative taps with full-scale pixels.
        load_taps(-128, -128, -128);
        start_row(3);
        for (int i = 0; i < 3; i++) send_px(255);
        wait_last_and_done();
        chk("t2_value", 32'(last_data), 32'h000E_8180);

        // Two-cycle bubble between pixels 3 and 4.
        load_taps(1, 2, 3);
        start_row(5);
        for (int v = 1; v <= 3; v++) send_px(v);
        chk("t3_ifmap_fire", 32'(bus_if.pe_ifmap), 32'h0003_0201);
        tick();
        chk("t3_ifmap_bubble1", 32'(bus_if.pe_ifmap), 32'h0);
        tick();
        chk("t3_ifmap_bubble2", 32'(bus_if.pe_ifmap), 32'h0);
        send_px(4);
        send_px(5);
        wait_last_and_done();
        chk("t3_gap_20", 32'(out_cycs[1] - out_cycs[0]), 32'd3);
        chk("t3_gap_26", 32'(out_cycs[2] - out_cycs[1]), 32'd1);

        // Start without weights, then illegal lengths.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        start_row(5);
        chk("t4_noweights_busy", 32'(bus_if.busy), 32'h0);
        chk("t4_noweights_err", 32'(bus_if.err), 32'h0);
        load_taps(1, 2, 3);
        start_row(2);
        chk("t4_short_err", 32'(bus_if.err), 32'h1);
        chk("t4_short_busy", 32'(bus_if.busy), 32'h0);
        tick();
        chk("t4_err_pulse_end", 32'(bus_if.err), 32'h0);
        start_row(MAX_W + 1);
        chk("t4_long_err", 32'(bus_if.err), 32'h1);
        chk("t4_long_busy", 32'(bus_if.busy), 32'h0);
        tick();

        // Reset in the middle of a row.
        start_row(5);
        for (int v = 1; v <= 3; v++) send_px(v);
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(bus_if.busy), 32'h0);
        chk("t5_px_ready", 32'(bus_if.px_ready), 32'h0);
        chk("t5_out_valid", 32'(bus_if.out_valid), 32'h0);
        chk("t5_pe_ifmap", 32'(bus_if.pe_ifmap), 32'h0);
        chk("t5_pe_filter", 32'(bus_if.pe_filter), 32'h0);
        chk("t5_out_data", 32'(bus_if.out_data), 32'h0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.done || bus_if.out_valid) bad++;
        end
        chk("t5_no_done_or_valid", 32'(bad), 32'h0);
        start_row(5);
        chk("t5_start_ignored", 32'(bus_if.busy), 32'h0);
        tick();

        // Back-to-back rows on reused taps; start issued in the done cycle.
        load_taps(1, 2, 3);
        start_row(3);
        for (int v = 1; v <= 3; v++) send_px(v);
        wait_last_and_done();
        start_row(3);
        chk("t6_b2b_busy", 32'(bus_if.busy), 32'h1);
        bus_if.w_valid = 1'b1;
        bus_if.w_data  = 8'h7F;
        chk("t6_w_ready_stream", 32'(bus_if.w_ready), 32'h0);
        send_px(4);
        bus_if.w_valid = 1'b0;
        send_px(5);
        send_px(6);
        wait_last_and_done();
        chk("t6_value", 32'(last_data), 32'd32);
        chk("t6_pe_filter", 32'(bus_if.pe_filter), 32'h0003_0201);
        tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
